// File: rtl/seg_pkg.sv
// Shared constants for the eight-digit multiplexed seven-segment scanner:
// digit geometry, prescaler width and the active-low segment lookup table.
package seg_pkg;

  localparam int DIGITS     = 8;
  localparam int CODE_W     = 4;
  localparam int SEG_W      = 7;
  localparam int PRESCALE_W = 20;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Active-low, bit 6 = A down to bit 0 = G; entries 10..15 are A,b,C,d,E,F.
  localparam logic [SEG_W-1:0] SEG_PATTERNS [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-code to active-low seven-segment pattern lookup.
import seg_pkg::*;

module seg7_decode (
  input  logic [CODE_W-1:0] code,
  output logic [SEG_W-1:0]  seg
);

  assign seg = SEG_PATTERNS[code];

endmodule

// File: rtl/seg_scan.sv
// Eight-digit multiplexed seven-segment scanner with frame-synchronous data update.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking of digits 7..1.
import seg_pkg::*;

module seg_scan #(
  parameter int DIV = 50000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [DIGITS*CODE_W-1:0]   digits_in,
  input  logic [DIGITS-1:0]          dp_in,
  output logic [SEG_W-1:0]           seg_n,
  output logic                       dp_n,
  output logic [DIGITS-1:0]          com_n,
  output logic                       scan_tick,
  output logic                       frame_done
);

  localparam logic [PRESCALE_W-1:0] COUNT_MAX = PRESCALE_W'(DIV - 1);

  logic [PRESCALE_W-1:0]      count;
  logic [2:0]                 index;
  logic                       tick;
  logic                       wrap;
  logic [DIGITS*CODE_W-1:0]   pend_digits;
  logic [DIGITS*CODE_W-1:0]   act_digits;
  logic [DIGITS-1:0]          pend_dp;
  logic [DIGITS-1:0]          act_dp;
  logic [CODE_W-1:0]          code;
  logic [SEG_W-1:0]           seg_raw;
  logic [SEG_W-1:0]           seg_next;
  logic                       blank;

  assign tick = (count == COUNT_MAX);
  assign wrap = tick && (index == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      index <= '0;
    end else if (tick) begin
      count <= '0;
      index <= index + 3'd1;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Active data only changes at the frame boundary so a frame never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_digits <= '0;
      pend_dp     <= '0;
      act_digits  <= '0;
      act_dp      <= '0;
    end else begin
      if (load) begin
        pend_digits <= digits_in;
        pend_dp     <= dp_in;
      end
      if (wrap) begin
        act_digits <= load ? digits_in : pend_digits;
        act_dp     <= load ? dp_in : pend_dp;
      end
    end
  end

  assign code = act_digits[{index, 2'b00} +: CODE_W];

  seg7_decode u_decode (
    .code (code),
    .seg  (seg_raw)
  );

`ifdef SEG_SCAN_LZB_EN
  logic [DIGITS-1:0] lead_zero;

  // A digit is a leading zero when it and every more-significant digit is 0.
  always_comb begin
    lead_zero    = '0;
    lead_zero[7] = (act_digits[31:28] == 4'd0);
    for (int k = 6; k >= 1; k--) begin
      lead_zero[k] = lead_zero[k+1] && (act_digits[k*4 +: 4] == 4'd0);
    end
  end

  assign blank = lead_zero[index];
`else
  assign blank = 1'b0;
`endif

  assign seg_next = blank ? SEG_BLANK : seg_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      com_n      <= 8'hFF;
      seg_n      <= SEG_BLANK;
      dp_n       <= 1'b1;
      scan_tick  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      com_n      <= ~(8'd1 << index);
      seg_n      <= seg_next;
      dp_n       <= ~act_dp[index];
      scan_tick  <= tick;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: a DIV=4 and a DIV=1 instance share stimulus and
// are compared every cycle against a slot/frame arithmetic model.
`timescale 1ns/1ps

module tb_seg_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [31:0] digits_in = '0;
  logic [7:0]  dp_in = '0;

  logic [1:0][6:0]  seg_o;
  logic [1:0]       dp_o;
  logic [1:0][7:0]  com_o;
  logic [1:0]       tick_o;
  logic [1:0]       frame_o;
  logic [1:0][17:0] obs;

  int checks = 0;
  int errors = 0;

  int          divs [2] = '{4, 1};
  int          m_cyc [2];
  logic [31:0] m_act_d [2];
  logic [31:0] m_pend_d [2];
  logic [7:0]  m_act_p [2];
  logic [7:0]  m_pend_p [2];
  logic [17:0] e_bus [2];

  localparam logic [17:0] OFF_BUS = {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0};

  always #5 clk = ~clk;

  seg_scan #(.DIV(4)) u_div4 (
    .clk(clk), .reset(reset), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .seg_n(seg_o[0]), .dp_n(dp_o[0]), .com_n(com_o[0]),
    .scan_tick(tick_o[0]), .frame_done(frame_o[0])
  );

  seg_scan #(.DIV(1)) u_div1 (
    .clk(clk), .reset(reset), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .seg_n(seg_o[1]), .dp_n(dp_o[1]), .com_n(com_o[1]),
    .scan_tick(tick_o[1]), .frame_done(frame_o[1])
  );

  assign obs[0] = {com_o[0], seg_o[0], dp_o[0], tick_o[0], frame_o[0]};
  assign obs[1] = {com_o[1], seg_o[1], dp_o[1], tick_o[1], frame_o[1]};

  function automatic logic [6:0] pattern(input logic [3:0] c);
    case (c)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic is_blank(input logic [31:0] d, input int k);
`ifdef SEG_SCAN_LZB_EN
    return (k >= 1) && ((d >> (4 * k)) == 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_clear;
    for (int u = 0; u < 2; u++) begin
      m_cyc[u]    = 0;
      m_act_d[u]  = '0;
      m_pend_d[u] = '0;
      m_act_p[u]  = '0;
      m_pend_p[u] = '0;
    end
  endtask

  // Edge number c shows slot c/DIV; the last edge of slot 7 swaps in the new frame.
  task automatic model_edge(input logic ld, input logic [31:0] d, input logic [7:0] p);
    int   digit;
    logic end_slot;
    logic [6:0] seg;
    for (int u = 0; u < 2; u++) begin
      digit    = (m_cyc[u] / divs[u]) % 8;
      end_slot = (m_cyc[u] % divs[u]) == divs[u] - 1;
      seg      = is_blank(m_act_d[u], digit) ? 7'h7F : pattern(m_act_d[u][digit*4 +: 4]);
      e_bus[u] = {~(8'd1 << digit), seg, ~m_act_p[u][digit], end_slot, end_slot && digit == 7};
      if (end_slot && digit == 7) begin
        m_act_d[u] = ld ? d : m_pend_d[u];
        m_act_p[u] = ld ? p : m_pend_p[u];
      end
      if (ld) begin
        m_pend_d[u] = d;
        m_pend_p[u] = p;
      end
      m_cyc[u]++;
    end
  endtask

  task automatic step(input logic ld, input logic [31:0] d, input logic [7:0] p);
    load      = ld;
    digits_in = d;
    dp_in     = p;
    @(posedge clk);
    model_edge(ld, d, p);
    #1;
  endtask

  task automatic release_reset;
    load = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] seq [5] = '{8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFD};
    int ticks = 0;
    int frames = 0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (obs[u] !== OFF_BUS) begin
        errors++;
        $display("[TB] FAIL reset_off u%0d got %h want %h", u, obs[u], OFF_BUS);
      end
    end
    release_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'd0, 8'd0);
      checks++;
      if (com_o[0] !== seq[i]) begin
        errors++;
        $display("[TB] FAIL release_com step%0d got %h want %h", i, com_o[0], seq[i]);
      end
    end
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 32'd0, 8'd0);
      ticks  += int'(tick_o[0]);
      frames += int'(frame_o[0]);
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (obs[u] !== e_bus[u]) begin
          errors++;
          $display("[TB] FAIL reset_run u%0d got %h want %h", u, obs[u], e_bus[u]);
        end
      end
    end
    checks++;
    if (ticks != 8 || frames != 1) begin
      errors++;
      $display("[TB] FAIL tick_rate got ticks=%0d frames=%0d want 8 1", ticks, frames);
    end
  endtask

  task automatic test_midframe_load;
    int n = 0;
    while (m_cyc[0] % 32 != 12) step(1'b0, digits_in, dp_in);
    step(1'b1, 32'h8765_4321, 8'h00);
    do begin
      step(1'b0, digits_in, dp_in);
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (obs[u] !== e_bus[u]) begin
          errors++;
          $display("[TB] FAIL midframe u%0d got %h want %h", u, obs[u], e_bus[u]);
        end
      end
      n++;
    end while (frame_o[0] !== 1'b1 && n < 64);
    checks++;
    if (n >= 64) begin
      errors++;
      $display("[TB] FAIL midframe_wait got timeout want frame_done");
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b0, digits_in, dp_in);
      checks++;
      if (seg_o[0] !== pattern(4'(k + 1)) || com_o[0] !== ~(8'd1 << k)) begin
        errors++;
        $display("[TB] FAIL new_frame digit%0d got %h/%h want %h", k, com_o[0], seg_o[0],
                 pattern(4'(k + 1)));
      end
      repeat (3) step(1'b0, digits_in, dp_in);
    end
  endtask

  task automatic test_wrap_load;
    while (m_cyc[0] % 32 != 31) step(1'b0, digits_in, dp_in);
    step(1'b1, 32'hA5C3_91E7, 8'h01);
    step(1'b0, digits_in, dp_in);
    checks++;
    if (com_o[0] !== 8'hFE || seg_o[0] !== pattern(4'h7) || dp_o[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_load got %h/%h/%b want fe/%h/0", com_o[0], seg_o[0], dp_o[0],
               pattern(4'h7));
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b0, digits_in, dp_in);
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (obs[u] !== e_bus[u]) begin
          errors++;
          $display("[TB] FAIL wrap_run u%0d got %h want %h", u, obs[u], e_bus[u]);
        end
      end
    end
  endtask

  task automatic test_lzb;
    logic [6:0] want;
    step(1'b1, 32'h0000_0100, 8'h00);
    for (int i = 0; i < 64; i++) begin
      step(1'b0, digits_in, dp_in);
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (obs[u] !== e_bus[u]) begin
          errors++;
          $display("[TB] FAIL lzb_run u%0d got %h want %h", u, obs[u], e_bus[u]);
        end
      end
    end
    while (m_cyc[0] % 32 != 0) step(1'b0, digits_in, dp_in);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, digits_in, dp_in);
`ifdef SEG_SCAN_LZB_EN
      want = (k == 2) ? pattern(4'h1) : (k >= 3) ? 7'h7F : pattern(4'h0);
`else
      want = (k == 2) ? pattern(4'h1) : pattern(4'h0);
`endif
      checks++;
      if (seg_o[0] !== want || com_o[0] !== ~(8'd1 << k)) begin
        errors++;
        $display("[TB] FAIL lzb digit%0d got %h/%h want %h", k, com_o[0], seg_o[0], want);
      end
      repeat (3) step(1'b0, digits_in, dp_in);
    end
  endtask

  task automatic test_dp_div1;
    logic [7:0] prev;
    step(1'b1, $urandom, 8'h04);
    repeat (20) step(1'b0, digits_in, dp_in);
    prev = com_o[1];
    for (int i = 0; i < 16; i++) begin
      step(1'b0, digits_in, dp_in);
      checks++;
      if ((dp_o[1] === 1'b0) !== (com_o[1] === 8'hFB) || com_o[1] === prev) begin
        errors++;
        $display("[TB] FAIL dp_div1 got com=%h prev=%h dp=%b want dp low only at fb",
                 com_o[1], prev, dp_o[1]);
      end
      checks++;
      if (obs[1] !== e_bus[1]) begin
        errors++;
        $display("[TB] FAIL div1_run got %h want %h", obs[1], e_bus[1]);
      end
      prev = com_o[1];
    end
  endtask

  task automatic test_random;
    logic ld;
    for (int i = 0; i < 400; i++) begin
      ld = ($urandom_range(0, 7) == 0);
      step(ld, ld ? 32'($urandom) : digits_in, ld ? 8'($urandom) : dp_in);
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (obs[u] !== e_bus[u]) begin
          errors++;
          $display("[TB] FAIL random u%0d cyc%0d got %h want %h", u, i, obs[u], e_bus[u]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe;
    step(1'b1, 32'hFEDC_BA98, 8'hFF);
    repeat (70) step(1'b0, digits_in, dp_in);
    while (m_cyc[0] % 4 != 1) step(1'b0, digits_in, dp_in);
    step(1'b1, 32'h1234_5678, 8'hAA);
    load = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (obs[u] !== OFF_BUS) begin
        errors++;
        $display("[TB] FAIL async_reset u%0d got %h want %h", u, obs[u], OFF_BUS);
      end
    end
    release_reset();
    for (int i = 0; i < 40; i++) begin
      step(1'b0, digits_in, dp_in);
      checks++;
      if (seg_o[0] !== 7'b0000001 || dp_o[0] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL zeros_after_reset cyc%0d got %h/%b want 01/1", i, seg_o[0], dp_o[0]);
      end
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (obs[u] !== e_bus[u]) begin
          errors++;
          $display("[TB] FAIL post_reset u%0d got %h want %h", u, obs[u], e_bus[u]);
        end
      end
    end
  endtask

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    test_reset();
    test_midframe_load();
    test_wrap_load();
    test_lzb();
    test_dp_div1();
    test_random();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
